bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
Arbiter and slave-select controller for the system bus. It shares the serial bus between two master ports (master_in_port / master_out_port pairs) using round-robin arbitration. It decodes the winning master's target slave ID into a one-hot slave select. It holds the grant until the transaction completes, the master withdraws, or a hold timeout expires, then inserts one turnaround cycle.

Parameters:
SLAVE_ID_LEN, 2, width of master slave-ID fields; IDs 0..2 valid, 3 invalid
HOLD_MAX, 4096, maximum cycles a grant may be held before forced release (≥2)
CNT_LEN, 12, width of hold counter; must satisfy 2^CNT_LEN ≥ HOLD_MAX

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
m1_request  input  1  master 1 bus request, level
m2_request  input  1  master 2 bus request, level
m1_slave_id  input  SLAVE_ID_LEN  master 1 target slave
m2_slave_id  input  SLAVE_ID_LEN  master 2 target slave
trans_done  input  1  one-cycle pulse from active slave/master at transaction end (rx_done/tx_done)
m1_grant  output  1  master 1 owns bus
m2_grant  output  1  master 2 owns bus
master_sel  output  1  bus mux select: 0 = master 1, 1 = master 2
slave_sel  output  3  one-hot slave enable, bit i = slave i
bus_busy  output  1  high in BUSY and RELEASE
timeout  output  1  one-cycle pulse on forced release
invalid_id  output  1  one-cycle pulse when a request carries ID 3

Behaviour:
- Reset (synchronous): state=IDLE; m1_grant=0, m2_grant=0, master_sel=0, slave_sel=000, bus_busy=0, timeout=0, invalid_id=0, hold counter=0, last_owner=2 (so master 1 wins first contention). Reset mid-transaction drops all grants at that edge.
- All outputs registered; timeout and invalid_id are single-cycle pulses, otherwise 0.
- States: IDLE, BUSY, RELEASE.
- IDLE:
  - Requests are "eligible" when request=1 and slave_id≤2.
  - Only one eligible request: grant it.
  - Both eligible: grant the master that is not last_owner.
  - Request with ID 3: ignored; invalid_id pulses the next cycle (once per IDLE evaluation cycle while it persists and no grant is issued).
  - On grant, next edge: state=BUSY, grant bit=1, master_sel=owner, slave_sel=onehot(owner's ID latched at grant), bus_busy=1, counter=0.
  - Latency: request sampled at edge n → grant visible after edge n+1 (1 cycle).
  - trans_done in IDLE is ignored.
- BUSY:
  - Grant, master_sel and latched slave_sel are held constant; slave_id changes are ignored.
  - Counter increments each cycle.
  - Exit to RELEASE on the first of: trans_done=1; owner request=0; counter==HOLD_MAX-1.
  - timeout pulses only on the counter exit.
  - Simultaneous trans_done or request drop with counter==HOLD_MAX-1 is a normal release; no timeout.
  - The non-owner request is ignored while BUSY.
- RELEASE (exactly 1 cycle):
  - Grants=0, slave_sel=000, bus_busy=1, master_sel holds its value.
  - last_owner updated to the released master.
  - Next state IDLE.
  - Minimum gap from grant drop to the next grant is 2 cycles (RELEASE, IDLE evaluation).
- Invariants: m1_grant & m2_grant never both 1; slave_sel is one-hot or zero; slave_sel≠0 only when a grant is high.
- A master keeping request high after release re-competes; round-robin guarantees the other requester is served first if it is waiting.

Test Plan:
- Reset, then m1_request=1, m1_slave_id=1 → m1_grant=1, master_sel=0, slave_sel=010 after 1 cycle; trans_done pulse → RELEASE cycle with grants=0, bus_busy=1 → IDLE, bus_busy=0.
- Both request after reset, m1 ID 0, m2 ID 2 → m1 granted (slave_sel=001); m1 done with both still requesting → m2 granted (slave_sel=100, master_sel=1) two cycles after m1_grant falls.
- HOLD_MAX=8, m2 requests ID 0 and never asserts trans_done → grant held exactly 8 cycles, timeout pulses once, grant drops, RELEASE, IDLE.
- m1_slave_id=3 with m1_request=1, m2 idle → no grant, invalid_id pulses each IDLE cycle; change ID to 2 → grant, slave_sel=100.
- Owner drops request mid-BUSY while m2 requests → release without timeout, m2 granted next; change owner's slave_id during BUSY → slave_sel unchanged.
- reset=1 during BUSY with m1_grant=1 → all outputs return to reset values after that edge; first grant after reset goes to m1 under contention.

Source files
------------

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter for two masters with one-hot slave select,
// bounded grant hold time and a one-cycle turnaround after every release.
module bus_arbiter #(
  parameter int SLAVE_ID_LEN = 2,
  parameter int HOLD_MAX     = 4096,
  parameter int CNT_LEN      = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    m1_request,
  input  logic                    m2_request,
  input  logic [SLAVE_ID_LEN-1:0] m1_slave_id,
  input  logic [SLAVE_ID_LEN-1:0] m2_slave_id,
  input  logic                    trans_done,
  output logic                    m1_grant,
  output logic                    m2_grant,
  output logic                    master_sel,
  output logic [2:0]              slave_sel,
  output logic                    bus_busy,
  output logic                    timeout,
  output logic                    invalid_id
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam logic [CNT_LEN-1:0] HOLD_LAST = CNT_LEN'(HOLD_MAX - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_LEN-1:0]  r_cnt;
  logic [CNT_LEN-1:0]  w_cnt_nxt;
  // Owner encoding: 0 = master 1, 1 = master 2.
  logic                r_last_owner;
  logic                w_last_owner_nxt;

  logic                r_m1_grant;
  logic                r_m2_grant;
  logic                r_master_sel;
  logic [2:0]          r_slave_sel;
  logic                r_bus_busy;
  logic                r_timeout;
  logic                r_invalid_id;

  logic                w_m1_grant_nxt;
  logic                w_m2_grant_nxt;
  logic                w_master_sel_nxt;
  logic [2:0]          w_slave_sel_nxt;
  logic                w_bus_busy_nxt;
  logic                w_timeout_nxt;
  logic                w_invalid_id_nxt;

  logic                w_m1_valid;
  logic                w_m2_valid;
  logic                w_m1_elig;
  logic                w_m2_elig;
  logic                w_winner;
  logic                w_owner_req;
  logic                w_hold_expired;

  function automatic logic id_is_valid(input logic [SLAVE_ID_LEN-1:0] id);
    return (id <= SLAVE_ID_LEN'(2));
  endfunction

  function automatic logic [2:0] id_onehot(input logic [SLAVE_ID_LEN-1:0] id);
    logic [2:0] sel;
    sel = 3'b000;
    if (id == SLAVE_ID_LEN'(0))      sel = 3'b001;
    else if (id == SLAVE_ID_LEN'(1)) sel = 3'b010;
    else if (id == SLAVE_ID_LEN'(2)) sel = 3'b100;
    return sel;
  endfunction

  assign w_m1_valid = id_is_valid(m1_slave_id);
  assign w_m2_valid = id_is_valid(m2_slave_id);
  assign w_m1_elig  = m1_request && w_m1_valid;
  assign w_m2_elig  = m2_request && w_m2_valid;

  // Under contention the master that did not own the bus last time wins.
  assign w_winner       = (w_m1_elig && w_m2_elig) ? ~r_last_owner : w_m2_elig;
  assign w_owner_req    = r_master_sel ? m2_request : m1_request;
  assign w_hold_expired = (r_cnt == HOLD_LAST);

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_last_owner_nxt = r_last_owner;
    w_m1_grant_nxt   = r_m1_grant;
    w_m2_grant_nxt   = r_m2_grant;
    w_master_sel_nxt = r_master_sel;
    w_slave_sel_nxt  = r_slave_sel;
    w_bus_busy_nxt   = r_bus_busy;
    w_timeout_nxt    = 1'b0;
    w_invalid_id_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_m1_grant_nxt  = 1'b0;
        w_m2_grant_nxt  = 1'b0;
        w_slave_sel_nxt = 3'b000;
        w_bus_busy_nxt  = 1'b0;
        if (w_m1_elig || w_m2_elig) begin
          w_state_nxt      = ST_BUSY;
          w_cnt_nxt        = '0;
          w_master_sel_nxt = w_winner;
          w_m1_grant_nxt   = ~w_winner;
          w_m2_grant_nxt   = w_winner;
          w_slave_sel_nxt  = w_winner ? id_onehot(m2_slave_id) : id_onehot(m1_slave_id);
          w_bus_busy_nxt   = 1'b1;
        end else if ((m1_request && !w_m1_valid) || (m2_request && !w_m2_valid)) begin
          w_invalid_id_nxt = 1'b1;
        end
      end

      ST_BUSY: begin
        if (trans_done || !w_owner_req || w_hold_expired) begin
          w_state_nxt      = ST_RELEASE;
          w_cnt_nxt        = '0;
          w_last_owner_nxt = r_master_sel;
          w_m1_grant_nxt   = 1'b0;
          w_m2_grant_nxt   = 1'b0;
          w_slave_sel_nxt  = 3'b000;
          w_bus_busy_nxt   = 1'b1;
          // A natural end in the same cycle as expiry is not a timeout.
          w_timeout_nxt    = w_hold_expired && !trans_done && w_owner_req;
        end else begin
          w_cnt_nxt = r_cnt + CNT_LEN'(1);
        end
      end

      ST_RELEASE: begin
        w_state_nxt     = ST_IDLE;
        w_m1_grant_nxt  = 1'b0;
        w_m2_grant_nxt  = 1'b0;
        w_slave_sel_nxt = 3'b000;
        w_bus_busy_nxt  = 1'b0;
      end

      default: begin
        w_state_nxt     = ST_IDLE;
        w_m1_grant_nxt  = 1'b0;
        w_m2_grant_nxt  = 1'b0;
        w_slave_sel_nxt = 3'b000;
        w_bus_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_last_owner <= 1'b1;
      r_m1_grant   <= 1'b0;
      r_m2_grant   <= 1'b0;
      r_master_sel <= 1'b0;
      r_slave_sel  <= 3'b000;
      r_bus_busy   <= 1'b0;
      r_timeout    <= 1'b0;
      r_invalid_id <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_m1_grant   <= w_m1_grant_nxt;
      r_m2_grant   <= w_m2_grant_nxt;
      r_master_sel <= w_master_sel_nxt;
      r_slave_sel  <= w_slave_sel_nxt;
      r_bus_busy   <= w_bus_busy_nxt;
      r_timeout    <= w_timeout_nxt;
      r_invalid_id <= w_invalid_id_nxt;
    end
  end

  assign m1_grant   = r_m1_grant;
  assign m2_grant   = r_m2_grant;
  assign master_sel = r_master_sel;
  assign slave_sel  = r_slave_sel;
  assign bus_busy   = r_bus_busy;
  assign timeout    = r_timeout;
  assign invalid_id = r_invalid_id;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed-vector bench for bus_arbiter; outputs are packed as
// {m1_grant, m2_grant, master_sel, slave_sel[2:0], bus_busy, timeout, invalid_id}.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       m1_request;
  logic       m2_request;
  logic [1:0] m1_slave_id;
  logic [1:0] m2_slave_id;
  logic       trans_done;
  logic       m1_grant;
  logic       m2_grant;
  logic       master_sel;
  logic [2:0] slave_sel;
  logic       bus_busy;
  logic       timeout;
  logic       invalid_id;
  logic [8:0] w_obs;

  int n_vec  = 0;
  int n_miss = 0;

  bus_arbiter #(
    .SLAVE_ID_LEN(2),
    .HOLD_MAX    (8),
    .CNT_LEN     (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .m1_request (m1_request),
    .m2_request (m2_request),
    .m1_slave_id(m1_slave_id),
    .m2_slave_id(m2_slave_id),
    .trans_done (trans_done),
    .m1_grant   (m1_grant),
    .m2_grant   (m2_grant),
    .master_sel (master_sel),
    .slave_sel  (slave_sel),
    .bus_busy   (bus_busy),
    .timeout    (timeout),
    .invalid_id (invalid_id)
  );

  always #5 clk = ~clk;

  assign w_obs = {m1_grant, m2_grant, master_sel, slave_sel, bus_busy, timeout, invalid_id};

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b expected %b (g1 g2 ms ss busy to inv)", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    m1_request  = 1'b0;
    m2_request  = 1'b0;
    m1_slave_id = 2'd0;
    m2_slave_id = 2'd0;
    trans_done  = 1'b0;
    tick();
    tick();
    chk("reset_state", w_obs, 9'b0_0_0_000_0_0_0);
    reset = 1'b0;

    // Single master, normal completion.
    m1_request = 1'b1; m1_slave_id = 2'd1;
    tick();
    chk("t1_grant", w_obs, 9'b1_0_0_010_1_0_0);
    trans_done = 1'b1;
    tick();
    chk("t1_release", w_obs, 9'b0_0_0_000_1_0_0);
    trans_done = 1'b0; m1_request = 1'b0;
    tick();
    chk("t1_idle", w_obs, 9'b0_0_0_000_0_0_0);

    // Contention after reset: m1 first, then m2 two cycles after drop.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t2_reset", w_obs, 9'b0_0_0_000_0_0_0);
    m1_request = 1'b1; m1_slave_id = 2'd0;
    m2_request = 1'b1; m2_slave_id = 2'd2;
    tick();
    chk("t2_m1_grant", w_obs, 9'b1_0_0_001_1_0_0);
    trans_done = 1'b1;
    tick();
    chk("t2_release", w_obs, 9'b0_0_0_000_1_0_0);
    trans_done = 1'b0;
    tick();
    chk("t2_idle_gap", w_obs, 9'b0_0_0_000_0_0_0);
    tick();
    chk("t2_m2_grant", w_obs, 9'b0_1_1_100_1_0_0);
    m1_request = 1'b0; m2_request = 1'b0;
    tick();
    chk("t2_m2_release", w_obs, 9'b0_0_1_000_1_0_0);
    tick();
    chk("t2_idle", w_obs, 9'b0_0_1_000_0_0_0);

    // Hold timeout with HOLD_MAX=8: grant held exactly 8 cycles.
    m2_request = 1'b1; m2_slave_id = 2'd0;
    tick();
    chk("t3_grant_c0", w_obs, 9'b0_1_1_001_1_0_0);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("t3_hold_c%0d", i), w_obs, 9'b0_1_1_001_1_0_0);
    end
    tick();
    chk("t3_timeout", w_obs, 9'b0_0_1_000_1_1_0);
    m2_request = 1'b0;
    tick();
    chk("t3_idle", w_obs, 9'b0_0_1_000_0_0_0);

    // Invalid slave ID, then corrected.
    m1_request = 1'b1; m1_slave_id = 2'd3;
    tick();
    chk("t4_invalid_a", w_obs, 9'b0_0_1_000_0_0_1);
    tick();
    chk("t4_invalid_b", w_obs, 9'b0_0_1_000_0_0_1);
    m1_slave_id = 2'd2;
    tick();
    chk("t4_grant", w_obs, 9'b1_0_0_100_1_0_0);
    m1_request = 1'b0;
    tick();
    chk("t4_release", w_obs, 9'b0_0_0_000_1_0_0);
    tick();
    chk("t4_idle", w_obs, 9'b0_0_0_000_0_0_0);

    // Owner withdraws mid-BUSY; ID change and other request ignored while busy.
    m1_request = 1'b1; m1_slave_id = 2'd0;
    tick();
    chk("t5_m1_grant", w_obs, 9'b1_0_0_001_1_0_0);
    m1_slave_id = 2'd2; m2_request = 1'b1; m2_slave_id = 2'd1;
    tick();
    chk("t5_id_ignored", w_obs, 9'b1_0_0_001_1_0_0);
    m1_request = 1'b0;
    tick();
    chk("t5_drop_release", w_obs, 9'b0_0_0_000_1_0_0);
    tick();
    chk("t5_idle", w_obs, 9'b0_0_0_000_0_0_0);
    tick();
    chk("t5_m2_grant", w_obs, 9'b0_1_1_010_1_0_0);
    m2_request = 1'b0;
    tick();
    chk("t5_m2_release", w_obs, 9'b0_0_1_000_1_0_0);
    tick();
    chk("t5_m2_idle", w_obs, 9'b0_0_1_000_0_0_0);

    // Reset during BUSY, then contention goes to m1.
    m1_request = 1'b1; m1_slave_id = 2'd1;
    tick();
    chk("t6_m1_grant", w_obs, 9'b1_0_0_010_1_0_0);
    m2_request = 1'b1; m2_slave_id = 2'd0;
    reset = 1'b1;
    tick();
    chk("t6_reset_busy", w_obs, 9'b0_0_0_000_0_0_0);
    reset = 1'b0;
    tick();
    chk("t6_first_after_reset", w_obs, 9'b1_0_0_010_1_0_0);
    m1_request = 1'b0; m2_request = 1'b0;
    tick();
    chk("t6_release", w_obs, 9'b0_0_0_000_1_0_0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
